bram_fifo_ctrl: RTL
===================

Name: bram_fifo_ctrl

Overview:
Streaming FIFO controller sitting directly upstream and downstream of bram_top. It drives the BRAM's single shared address port, write data, WE and RE, and takes back its registered q. Writers get a valid/ready push interface. Readers get a valid/ready pop interface backed by a 2-entry prefetch buffer, which hides the 1-cycle BRAM read latency.

Parameters:
- DATA_W, 8: data width; matches the bram_top data/q width.
- ADDR_W, 8: BRAM address width. Storage depth is DEPTH = 2**ADDR_W = 256.

Ports:
- clk, input, 1: single clock; all state and the BRAM update on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous clear of all FIFO state.
- in_data, input, DATA_W: push data.
- in_valid, input, 1: push request.
- in_ready, output, 1: push accepted when in_valid and in_ready are both high at a clk edge.
- out_data, output, DATA_W: head-of-FIFO data.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: pop occurs when out_valid and out_ready are both high at a clk edge.
- count, output, ADDR_W+3: total entries held, covering BRAM, in-flight read and prefetch buffer.
- full, output, 1: BRAM storage is full.
- empty, output, 1: count == 0.
- addrs, output, ADDR_W: to bram_top addrs (shared read/write address).
- data, output, DATA_W: to bram_top data.
- WE, output, 1: to bram_top WE.
- RE, output, 1: to bram_top RE.
- q, input, DATA_W: from bram_top q. Valid in the cycle after the edge at which RE=1 was sampled.

Behaviour:
- Internal state:
  - wr_ptr, rd_ptr: ADDR_W bits each; wrap naturally 255 -> 0.
  - mem_cnt: 0..DEPTH, ADDR_W+1 bits.
  - rd_pend: 1 bit, marks a read in flight.
  - buf_cnt: 0..2, with a 2-entry prefetch buffer.
- Per-cycle grant (combinational from registered state; exactly one of IDLE, WRITE, READ):
  - READ if mem_cnt>0 and buf_cnt+rd_pend<2 and (buf_cnt==0 or !in_valid).
  - Otherwise WRITE if in_valid and mem_cnt<DEPTH.
  - Otherwise IDLE.
  - Read has priority only when the output would otherwise starve; write has priority otherwise.
- in_ready = (mem_cnt<DEPTH) && grant!=READ && !flush && !rst. It never depends on out_ready.
- BRAM drive:
  - WRITE: WE=1, RE=0, addrs=wr_ptr, data=in_data.
  - READ: RE=1, WE=0, addrs=rd_ptr.
  - IDLE: WE=0, RE=0, addrs=rd_ptr, data=0.
  - WE and RE are never both 1.
- On a WRITE edge: wr_ptr+1, mem_cnt+1.
- On a READ edge: rd_ptr+1, mem_cnt-1, rd_pend<=1.
- On the edge after a read (rd_pend=1): q is captured into the buffer tail, rd_pend<=0.
- Prefetch buffer:
  - FIFO order.
  - out_data = head; out_valid = (buf_cnt>0); both registered.
  - Pop and capture on the same edge: buf_cnt is unchanged and the captured word goes behind the remaining entry.
  - buf_cnt can never overflow, by construction of the READ condition.
- Latency: a word pushed into an empty FIFO at edge E0 is read at E1, captured at E2, and out_valid=1 after E2 (2 cycles).
- Sustained rate: one word per cycle in total across push and pop. The single address port makes simultaneous push and pop share bandwidth.
- count = mem_cnt + rd_pend + buf_cnt.
- full = (mem_cnt==DEPTH). Total capacity is DEPTH+2.
- rst (async, any time), and flush (at the next edge):
  - Pointers, mem_cnt, rd_pend and buf_cnt go to 0.
  - out_valid=0, out_data=0, empty=1, full=0, count=0.
  - A read in flight at flush is discarded.
  - BRAM contents are not cleared.
  - While rst=1: WE=0, RE=0, in_ready=0.
- A push offered while full stalls (in_ready=0); a pop while empty is ignored. Neither corrupts state.

Decomposition:
- Shared package bram_pkg:
  - DATA_W, ADDR_W, DEPTH constants.
  - Grant encoding constants GNT_IDLE=2'd0, GNT_WRITE=2'd1, GNT_READ=2'd2.
- One sub-module, bram_prefetch_buf: the 2-entry capture/pop buffer with buf_cnt, out_data and out_valid.

Test Plan:
- Reset then idle -> WE=0, RE=0, empty=1, count=0, in_ready=1, out_valid=0.
- Push 8'haa then 8'hba, out_ready=0:
  - WE=1 @ addrs 8'h00 then 8'h01.
  - A READ of 8'h00 is interleaved while buf_cnt==0.
  - out_data=8'haa, out_valid=1 two cycles after the first push; count=2.
- Push 258 words (0..257, data = index[7:0]) with out_ready=0:
  - full=1 after 256 words held in BRAM plus 2 buffered.
  - in_ready=0 thereafter.
  - Drain with out_ready=1: pops 0..255,0,1 in order; addrs wraps 8'hff -> 8'h00.
- Continuous push with out_ready=1 -> no loss, order preserved, WE and RE never both high, count ≤ 3 in steady state.
- flush asserted with 5 entries and a read in flight -> next cycle count=0, out_valid=0; a subsequent push of 8'h5a pops 8'h5a.
- rst asserted mid-stream between edges -> outputs clear immediately (asynchronously); after release, FIFO behaves as empty.

Source files
------------

// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared constants for the BRAM-backed streaming FIFO.
// Grant codes select which side owns the single BRAM port.
package bram_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2**ADDR_W;

  typedef logic [1:0] gnt_t;

  localparam gnt_t GNT_IDLE  = 2'd0;
  localparam gnt_t GNT_WRITE = 2'd1;
  localparam gnt_t GNT_READ  = 2'd2;

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// Push/pop stream handshakes plus FIFO status.
// master = producer/consumer side, slave = FIFO controller.
interface bram_fifo_ctrl_if
  import bram_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
);

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW+2:0] count;
  logic          full;
  logic          empty;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  count,
    input  full,
    input  empty
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output count,
    output full,
    output empty
  );

endinterface

// File: rtl/bram_prefetch_buf.sv
// Two-entry capture/pop buffer that hides the BRAM read latency.
// Entry b0 is the head; a capture lands behind whatever remains.
module bram_prefetch_buf
  import bram_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          cap,
  input  logic [DW-1:0] cap_data,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic [1:0]    buf_cnt
);

  logic [DW-1:0] b0, b1;
  logic [DW-1:0] b0_n, b1_n;
  logic [1:0]    cnt_n;
  logic          pop;

  assign pop      = out_ready && (buf_cnt != 2'd0);
  assign out_data = b0;

  always_comb begin
    b0_n  = b0;
    b1_n  = b1;
    cnt_n = buf_cnt;
    unique case ({pop, cap})
      2'b11: begin
        if (buf_cnt == 2'd1) begin
          b0_n = cap_data;
        end else begin
          b0_n = b1;
          b1_n = cap_data;
        end
      end
      2'b10: begin
        b0_n  = b1;
        cnt_n = buf_cnt - 2'd1;
      end
      2'b01: begin
        if (buf_cnt == 2'd0) b0_n = cap_data;
        else                 b1_n = cap_data;
        cnt_n = buf_cnt + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b0        <= '0;
      b1        <= '0;
      buf_cnt   <= 2'd0;
      out_valid <= 1'b0;
    end else if (flush) begin
      b0        <= '0;
      b1        <= '0;
      buf_cnt   <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      b0        <= b0_n;
      b1        <= b1_n;
      buf_cnt   <= cnt_n;
      out_valid <= (cnt_n != 2'd0);
    end
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Streaming FIFO controller over a single-port BRAM (bram_top).
// Arbitrates the shared address port between push writes and prefetch reads.
module bram_fifo_ctrl
  import bram_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  bram_fifo_ctrl_if.slave    strm,
  output logic [AW-1:0]      addrs,
  output logic [DW-1:0]      data,
  output logic               WE,
  output logic               RE,
  input  logic [DW-1:0]      q
);

  localparam logic [AW:0] DEP = (AW+1)'(2**AW);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   mem_cnt;
  logic          rd_pend;
  logic [1:0]    buf_cnt;
  gnt_t          gnt;
  logic          mem_nz, mem_nf, rd_ok;

  assign mem_nz = (mem_cnt != '0);
  assign mem_nf = (mem_cnt != DEP);
  assign rd_ok  = mem_nz &&
                  (({1'b0, buf_cnt} + {2'b00, rd_pend}) < 3'd2);

  // Reads win only when the head would otherwise run dry.
  always_comb begin
    gnt = GNT_IDLE;
    if (rst || flush) begin
      gnt = GNT_IDLE;
    end else if (rd_ok && (buf_cnt == 2'd0 || !strm.in_valid)) begin
      gnt = GNT_READ;
    end else if (strm.in_valid && mem_nf) begin
      gnt = GNT_WRITE;
    end
  end

  assign strm.in_ready = mem_nf && (gnt != GNT_READ) && !flush && !rst;

  always_comb begin
    WE    = 1'b0;
    RE    = 1'b0;
    addrs = rd_ptr;
    data  = '0;
    unique case (1'b1)
      (gnt == GNT_WRITE): begin
        WE    = 1'b1;
        addrs = wr_ptr;
        data  = strm.in_data;
      end
      (gnt == GNT_READ): begin
        RE    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      rd_pend <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= (gnt == GNT_READ);
      if (gnt == GNT_WRITE) begin
        wr_ptr  <= wr_ptr + AW'(1);
        mem_cnt <= mem_cnt + (AW+1)'(1);
      end
      if (gnt == GNT_READ) begin
        rd_ptr  <= rd_ptr + AW'(1);
        mem_cnt <= mem_cnt - (AW+1)'(1);
      end
    end
  end

  bram_prefetch_buf #(.DW(DW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .cap       (rd_pend),
    .cap_data  (q),
    .out_ready (strm.out_ready),
    .out_data  (strm.out_data),
    .out_valid (strm.out_valid),
    .buf_cnt   (buf_cnt)
  );

  assign strm.count = (AW+3)'(mem_cnt) + (AW+3)'(rd_pend) +
                      (AW+3)'(buf_cnt);
  assign strm.full  = !mem_nf;
  assign strm.empty = (strm.count == '0);

endmodule
